tanh4_in_quantizer: RTL and testbench

Streaming quantizer stage directly upstream of the 4-bit approximate tanh circuits. It takes signed accumulator words from the MAC array, rounds and arithmetically right-shifts them, and saturates them to the 4-bit two's-complement activation code. It presents that code to the tanh circuit on `m_code` through a valid/ready interface with a 2-entry skid buffer. It also counts saturation events for quantization-range tuning.

---
 rtl/tanh4_in_quantizer.sv | 80 ++++++++
 tb/tb_tanh4_in_quantizer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tanh4_in_quantizer.sv
// tanh4_in_quantizer: round/shift/saturate accumulator words to a 4-bit code
// and buffer them in a 2-entry skid FIFO ahead of the tanh stage.
module tanh4_in_quantizer #(
   parameter int ACC_W = 16,
   parameter int SHIFT = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [ACC_W-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [3:0]       m_code,
   output logic             m_sat,
   input  logic             sat_clr,
   output logic [CNT_W-1:0] sat_cnt
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT-1);
   state_t state_q, state_d;
   logic [4:0] head_q, head_d, tail_q, tail_d, ent;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic signed [ACC_W:0] sum;
   logic [ACC_W:0] r;
   logic hi, lo, acc, xfer;
   // One guard bit keeps the half-up rounding add from wrapping at the top of range.
   always_comb begin
      sum = $signed({s_data[ACC_W-1], s_data} + HALF);
      r   = sum >>> SHIFT;
      hi  = !r[ACC_W] && (r[ACC_W-1:3] != '0);
      lo  = r[ACC_W] && !(&r[ACC_W-1:3]);
      ent = hi ? 5'b1_0111 : lo ? 5'b1_1000 : {1'b0, r[3:0]};
   end
   assign s_ready = state_q != TWO;
   assign m_valid = state_q != EMPTY;
   assign m_code  = head_q[3:0];
   assign m_sat   = head_q[4];
   assign sat_cnt = cnt_q;
   assign acc     = s_valid && s_ready;
   assign xfer    = m_valid && m_ready;
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: if (acc) begin
            state_d = ONE;
            head_d  = ent;
         end
         ONE: begin
            if (acc && xfer) head_d = ent;
            else if (acc) begin
               state_d = TWO;
               tail_d  = ent;
            end else if (xfer) state_d = EMPTY;
         end
         default: if (xfer) begin
            state_d = ONE;
            head_d  = tail_q;
         end
      endcase
      cnt_d = sat_clr ? CNT_W'(acc && ent[4]) :
              (acc && ent[4] && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_tanh4_in_quantizer.sv
// tb_tanh4_in_quantizer: directed vectors plus a randomized queue-model run.
module tb_tanh4_in_quantizer;
   logic clk = 0, rst_n = 0, s_valid = 0, m_ready = 0, sat_clr = 0;
   logic [15:0] s_data = '0;
   logic s_ready, m_valid, m_sat, s_ready4, m_valid4, m_sat4;
   logic [3:0] m_code, m_code4, sat_cnt4;
   logic [15:0] sat_cnt;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   tanh4_in_quantizer dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_code(m_code), .m_sat(m_sat),
      .sat_clr(sat_clr), .sat_cnt(sat_cnt));
   tanh4_in_quantizer #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
      .m_valid(m_valid4), .m_ready(m_ready), .m_code(m_code4), .m_sat(m_sat4),
      .sat_clr(sat_clr), .sat_cnt(sat_cnt4));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic send(input logic [15:0] d, input logic [3:0] ec, input logic es);
      @(negedge clk);
      s_valid = 1;
      s_data  = d;
      @(posedge clk);
      #1;
      s_valid = 0;
      chk("lat_valid", m_valid, 1);
      chk("lat_code", m_code, ec);
      chk("lat_sat", m_sat, es);
   endtask
   task automatic drain();
      @(negedge clk);
      m_ready = 1;
      s_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("drain_empty", m_valid, 0);
   endtask
   function automatic logic [4:0] model(input logic [15:0] d);
      int r;
      r = ($signed(d) + 128) >>> 8;
      return (r > 7) ? 5'h17 : (r < -8) ? 5'h18 : {1'b0, 4'(r)};
   endfunction
   initial begin
      logic [4:0] q[$];
      logic [31:0] rnd;
      logic av, xv;
      int mcnt;
      #1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_code", m_code, 0);
      chk("rst_m_sat", m_sat, 0);
      chk("rst_sat_cnt", sat_cnt, 0);
      @(negedge clk);
      rst_n   = 1;
      m_ready = 1;
      send(16'h0180, 4'h2, 0);
      send(16'h0700, 4'h7, 0);
      send(16'hF880, 4'h9, 0);
      send(16'hF780, 4'h8, 0);
      chk("nosat_cnt", sat_cnt, 0);
      send(16'h0780, 4'h7, 1);
      send(16'h7FFF, 4'h7, 1);
      send(16'h8000, 4'h8, 1);
      send(16'hF77F, 4'h8, 1);
      chk("sat_cnt4", sat_cnt, 4);
      drain();
      // backpressure: A=2, B=3, C=4
      @(negedge clk);
      m_ready = 0;
      s_valid = 1;
      s_data  = 16'h0180;
      @(posedge clk); #1;
      chk("bp_a_ready", s_ready, 1);
      chk("bp_a_code", m_code, 2);
      @(negedge clk);
      s_data = 16'h0300;
      @(posedge clk); #1;
      chk("bp_full_ready", s_ready, 0);
      chk("bp_full_code", m_code, 2);
      @(negedge clk);
      s_data = 16'h0400;
      @(posedge clk); #1;
      chk("bp_hold_ready", s_ready, 0);
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_code", m_code, 2);
      @(negedge clk);
      m_ready = 1;
      @(posedge clk); #1;
      chk("bp_b_code", m_code, 3);
      chk("bp_b_ready", s_ready, 1);
      @(negedge clk);
      @(posedge clk); #1;
      s_valid = 0;
      chk("bp_c_code", m_code, 4);
      chk("bp_c_valid", m_valid, 1);
      chk("bp_c_ready", s_ready, 1);
      @(posedge clk); #1;
      chk("bp_end_valid", m_valid, 0);
      // clear coinciding with a saturating accept, then clear alone
      @(negedge clk);
      s_valid = 1;
      s_data  = 16'h7FFF;
      sat_clr = 1;
      @(posedge clk); #1;
      chk("clr_sat_accept", sat_cnt, 1);
      @(negedge clk);
      s_valid = 0;
      @(posedge clk); #1;
      chk("clr_alone", sat_cnt, 0);
      sat_clr = 0;
      for (int i = 0; i < 20; i++) send(16'h8000, 4'h8, 1);
      chk("cnt4_hold", sat_cnt4, 4'hF);
      chk("cnt16_20", sat_cnt, 20);
      drain();
      // asynchronous reset with two entries buffered
      @(negedge clk);
      m_ready = 0;
      s_valid = 1;
      s_data  = 16'h7FFF;
      repeat (2) @(posedge clk);
      #1;
      s_valid = 0;
      chk("pre_rst_ready", s_ready, 0);
      chk("pre_rst_sat", m_sat, 1);
      #2;
      rst_n = 0;
      #1;
      chk("arst_ready", s_ready, 1);
      chk("arst_valid", m_valid, 0);
      chk("arst_code", m_code, 0);
      chk("arst_sat", m_sat, 0);
      chk("arst_cnt", sat_cnt, 0);
      @(negedge clk);
      rst_n   = 1;
      m_ready = 1;
      send(16'h0180, 4'h2, 0);
      drain();
      // random run against a queue model
      @(negedge clk);
      sat_clr = 1;
      @(negedge clk);
      sat_clr = 0;
      mcnt = 0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         rnd = $urandom;
         s_valid = rnd[0];
         m_ready = rnd[1] | rnd[2];
         rnd = $urandom;
         s_data = rnd[31] ? {{4{rnd[11]}}, rnd[11:0]} : rnd[15:0];
         chk("rnd_m_valid", m_valid, q.size() != 0);
         chk("rnd_s_ready", s_ready, q.size() < 2);
         av = s_valid && s_ready;
         xv = m_valid && m_ready;
         if (xv && q.size() != 0) begin
            chk("rnd_entry", {m_sat, m_code}, q[0]);
            void'(q.pop_front());
         end
         if (av) begin
            q.push_back(model(s_data));
            if (model(s_data) > 5'h0F) mcnt++;
         end
      end
      @(negedge clk);
      s_valid = 0;
      chk("rnd_sat_cnt", sat_cnt, 16'(mcnt));
      m_ready = 1;
      while (q.size() != 0) begin
         @(posedge clk); #1;
         void'(q.pop_front());
      end
      chk("rnd_drained", m_valid, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
